// File: rtl/instr_asm_pkg.sv
// Shared types and constants for the byte-to-word instruction assembler.
package instr_asm_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } asm_state_e;

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // Slot 0 lands in the most significant byte, so bytes arrive MSB first.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input byte_idx_t   idx,
                                             input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[(BYTES_PER_WORD - 1 - int'(idx)) * 8 +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/instr_assembler_idle_timer.sv
// Inter-byte idle counter; only built when INSTR_ASM_TIMEOUT_EN is defined.
`ifdef INSTR_ASM_TIMEOUT_EN
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The expiring cycle is the TIMEOUT_CYCLES-th idle edge after the last byte.
  assign expire_o = run_i && !clear_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/instr_assembler.sv
// Packs four MSB-first bytes into a 32-bit instruction and writes it to program memory.
// Optional inter-byte timeout is enabled by defining INSTR_ASM_TIMEOUT_EN.
module instr_assembler
  import instr_asm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [31:0]           instr,
  output logic [15:0]           imm,
  output logic                  word_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  mem_full,
  output logic                  timeout_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  asm_state_e            state_q, state_d;
  byte_idx_t             byte_idx_q, byte_idx_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           instr_q, instr_d;
  logic [15:0]           imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  mem_full_q, mem_full_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  timer_expire;
  logic [31:0]           assembled;

`ifdef INSTR_ASM_TIMEOUT_EN
  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock   (clock),
    .reset   (reset),
    .run_i   ((state_q == COLLECT) && (byte_idx_q != '0) && load),
    .clear_i (load && rx_valid),
    .expire_o(timer_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timer_expire       = 1'b0;
`endif

  assign assembled = place_byte(shift_q, byte_idx_q, rx_data);

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shift_d       = shift_q;
    instr_d       = instr_q;
    imm_d         = imm_q;
    wr_addr_d     = wr_addr_q;
    mem_full_d    = mem_full_q;
    timeout_err_d = 1'b0;

    // The address bookkeeping for a finished word happens as WRITE ends,
    // regardless of where the FSM goes next.
    if (state_q == WRITE && !mem_full_q) begin
      if (wr_addr_q == ADDR_MAX) begin
        mem_full_d = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = COLLECT;
          byte_idx_d = '0;
          wr_addr_d  = '0;
          mem_full_d = 1'b0;
        end
      end
      COLLECT, WRITE: begin
        if (!load) begin
          state_d    = IDLE;
          byte_idx_d = '0;
        end else if (rx_valid) begin
          shift_d = assembled;
          if (byte_idx_q == LAST_BYTE_IDX) begin
            state_d    = WRITE;
            byte_idx_d = '0;
            instr_d    = assembled;
            imm_d      = assembled[15:0];
          end else begin
            state_d    = COLLECT;
            byte_idx_d = byte_idx_q + byte_idx_t'(1);
          end
        end else if (timer_expire) begin
          state_d       = COLLECT;
          byte_idx_d    = '0;
          timeout_err_d = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d    = IDLE;
        byte_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      instr_q       <= '0;
      imm_q         <= '0;
      wr_addr_q     <= '0;
      mem_full_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      wr_addr_q     <= wr_addr_d;
      mem_full_q    <= mem_full_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Partial-word storage needs no reset: every slot is rewritten before use.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign instr       = instr_q;
  assign imm         = imm_q;
  assign word_valid  = (state_q == WRITE);
  assign wr_en       = (state_q == WRITE) && !mem_full_q;
  assign wr_addr     = wr_addr_q;
  assign mem_full    = mem_full_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: directed scenarios plus random byte streams.
module tb_instr_assembler;

  localparam int AW = 2;
  localparam int TO = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          load;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [31:0]   instr;
  logic [15:0]   imm;
  logic          word_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          mem_full;
  logic          timeout_err;

  always #5 clock = ~clock;

  instr_assembler #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .instr      (instr),
    .imm        (imm),
    .word_valid (word_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .mem_full   (mem_full),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] word;
    int          addr;
    bit          we;
    bit          mf;
  } word_exp_t;

  typedef struct {
    bit          rst;
    bit          to;
    logic [31:0] last;
  } cyc_exp_t;

  word_exp_t wq[$];
  cyc_exp_t  cq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: a byte list per word, a next-address counter and a full flag.
  bit          m_active = 0;
  logic [7:0]  m_bytes[$];
  int          m_addr = 0;
  bit          m_full = 0;
  int          m_idle = 0;
  logic [31:0] m_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit l, input bit v, input logic [7:0] d);
    cyc_exp_t    c;
    word_exp_t   w;
    c.rst = !r;
    c.to  = 0;
    if (!r) begin
      m_active = 0; m_bytes.delete(); m_addr = 0; m_full = 0; m_idle = 0; m_last = '0;
    end else if (!l) begin
      m_active = 0; m_bytes.delete(); m_idle = 0;
    end else if (!m_active) begin
      m_active = 1; m_bytes.delete(); m_addr = 0; m_full = 0; m_idle = 0;
    end else if (v) begin
      m_bytes.push_back(d);
      m_idle = 0;
      if (m_bytes.size() == 4) begin
        w.word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        w.addr = m_addr;
        w.we   = !m_full;
        w.mf   = m_full;
        wq.push_back(w);
        m_last = w.word;
        if (!m_full) begin
          if (m_addr == (1 << AW) - 1) m_full = 1;
          else m_addr++;
        end
        m_bytes.delete();
      end
    end else if (m_bytes.size() != 0) begin
`ifdef INSTR_ASM_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_bytes.delete();
        m_idle = 0;
        c.to   = 1;
      end
`endif
    end
    c.last = m_last;
    cq.push_back(c);
  endtask

  task automatic cycle(input bit r, input bit l, input bit v, input logic [7:0] d);
    reset    = r;
    load     = l;
    rx_valid = v;
    rx_data  = d;
    model_step(r, l, v, d);
    @(posedge clock);
    #2;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) cycle(1, 1, 1, w[i*8 +: 8]);
  endtask

  task automatic idle(input int n, input bit l);
    for (int i = 0; i < n; i++) cycle(1, l, 0, 8'h00);
  endtask

  // Monitor: per-cycle state checks plus a word scoreboard popped on word_valid.
  initial begin
    cyc_exp_t  c;
    word_exp_t w;
    forever begin
      @(negedge clock);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        if (c.rst) begin
          check("rst_word_valid", 32'(word_valid), 32'd0);
          check("rst_wr_en", 32'(wr_en), 32'd0);
          check("rst_wr_addr", 32'(wr_addr), 32'd0);
          check("rst_mem_full", 32'(mem_full), 32'd0);
        end
        check("timeout_err", 32'(timeout_err), 32'(c.to));
        check("instr_hold", instr, c.last);
        check("imm_hold", 32'(imm), 32'(c.last[15:0]));
      end
      if (word_valid) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=%h required=none", instr);
        end else begin
          w = wq.pop_front();
          check("word_instr", instr, w.word);
          check("word_wr_en", 32'(wr_en), 32'(w.we));
          check("word_wr_addr", 32'(wr_addr), 32'(w.addr));
          check("word_mem_full", 32'(mem_full), 32'(w.mf));
        end
      end else begin
        check("wr_en_without_word", 32'(wr_en), 32'd0);
      end
    end
  end

  initial begin
    bit   ld;
    int   rate;
    logic [31:0] burst [5];
    burst = '{32'h01020304, 32'hAABBCCDD, 32'h55667788, 32'h99A0B0C0, 32'hDEADBEEF};

    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    idle(1, 0);

    // First word at address 0, next at address 1.
    idle(1, 1);
    send_word(32'h3C01ABCD);
    idle(1, 1);
    send_word($urandom);
    idle(2, 1);

    // Partial word discarded by load falling.
    idle(1, 0);
    idle(1, 1);
    cycle(1, 1, 1, 8'h77);
    cycle(1, 1, 1, 8'h66);
    idle(1, 0);
    idle(1, 1);
    send_word(32'h11223344);
    idle(2, 1);

    // Back-to-back words, bytes landing in WRITE cycles, fill and overflow memory.
    idle(1, 0);
    idle(1, 1);
    for (int i = 0; i < 5; i++) send_word(burst[i]);
    idle(2, 1);

    // Reset in the middle of a word.
    idle(1, 0);
    idle(1, 1);
    cycle(1, 1, 1, 8'h12);
    cycle(1, 1, 1, 8'h34);
    cycle(1, 1, 1, 8'h56);
    cycle(0, 1, 0, 8'h00);
    idle(1, 1);
    send_word(32'hCAFEF00D);
    idle(2, 1);

    // Long idle after one byte (times out only when the feature is built in).
    cycle(1, 1, 1, 8'hE1);
    idle(12, 1);
    send_word(32'h0BADC0DE);
    idle(2, 1);

    // Random traffic with varying byte rates, load drops and occasional resets.
    ld   = 1;
    rate = 6;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) rate = $urandom_range(1, 9);
      if ($urandom_range(0, 49) == 0) ld = !ld;
      cycle(($urandom_range(0, 199) != 0), ld, ($urandom_range(0, 9) < rate), 8'($urandom));
    end

    idle(5, 0);
    check("words_outstanding", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Byte-to-word instruction assembler between the UART receiver and program memory / immediate datapath. Packs four received bytes (MSB first) into a 32-bit instruction and writes it to program memory at an auto-incrementing address. Presents the completed word and its 16-bit immediate field, with a one-cycle strobe that drives the zero-extender's enable directly.

## Interface
Parameters:
- ADDR_WIDTH, 8, program-memory word-address width
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clock cycles (used only with INSTR_ASM_TIMEOUT_EN)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- load  in  1  load mode; bytes are accepted only while high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- instr  out  32  last completed instruction word
- imm  out  16  instr[15:0], registered; feeds extender data input
- word_valid  out  1  one-cycle strobe, instr/imm updated this cycle
- wr_en  out  1  program-memory write enable (one cycle)
- wr_addr  out  ADDR_WIDTH  program-memory write address
- mem_full  out  1  sticky: last address written, further words dropped
- timeout_err  out  1  one-cycle strobe: partial word discarded on timeout

## Operation
- States: IDLE (load low), COLLECT (byte_idx 0..3), WRITE (one cycle).
- IDLE -> COLLECT on load rising edge; this edge also clears wr_addr to 0, mem_full to 0, byte_idx to 0.
- COLLECT: rx_valid with load high stores rx_data at byte slot byte_idx (idx0 -> [31:24], idx3 -> [7:0]), byte_idx++.
- Fourth byte accepted -> WRITE. In WRITE: instr/imm load the assembled word, word_valid=1; wr_en=1 at wr_addr unless mem_full.
- Leaving WRITE: wr_addr++ ; if wr_addr was 2^ADDR_WIDTH-1, wr_addr holds and mem_full sets instead. Return to COLLECT, byte_idx 0.
- Byte arriving in WRITE is accepted as byte 0 of the next word (no byte loss).
- mem_full set: words still assemble and pulse word_valid; wr_en stays 0, wr_addr unchanged.
- load falls in any state: partial word discarded, byte_idx 0, -> IDLE; wr_addr and mem_full retained. A byte coinciding with load low is ignored. If load falls in WRITE, that write still completes.
- rx_valid with load low: ignored.

## Timing
- Reset (reset=0 at edge): instr=0, imm=0, word_valid=0, wr_en=0, wr_addr=0, mem_full=0, timeout_err=0, byte_idx=0, state IDLE. Reset mid-word discards everything.
- Latency: 4th rx_valid at edge N -> word_valid/wr_en high for cycle N+1 only; wr_addr valid alongside wr_en; zero-extender output valid at edge N+2.
- instr/imm hold between strobes.
- wr_addr increments at the edge ending WRITE.

## Configuration
- INSTR_ASM_TIMEOUT_EN defined: cycle counter runs while byte_idx != 0, clears on each accepted byte; reaching TIMEOUT_CYCLES discards partial word, byte_idx 0, timeout_err high one cycle, state stays COLLECT.
- Undefined: no counter; partial words held indefinitely; timeout_err tied 0.

## Structure
- Package instr_asm_pkg: state enum (IDLE, COLLECT, WRITE), BYTES_PER_WORD=4, byte-slot index width.
- Optional sub-module idle_timer (timeout counter, present only under INSTR_ASM_TIMEOUT_EN); rest flat.

## Test plan
- Reset, load=1, bytes 0x3C,0x01,0xAB,0xCD -> one cycle later instr=0x3C01ABCD, imm=0xABCD, word_valid=wr_en=1, wr_addr=0; next word writes at addr 1.
- Two bytes, then load low, load high, four bytes 0x11,0x22,0x33,0x44 -> instr=0x11223344 at wr_addr=0, partial discarded.
- ADDR_WIDTH=2, five words -> wr_en for addr 0..3, mem_full=1 after 4th, 5th word word_valid=1 and wr_en=0.
- Byte 0xAA in WRITE cycle plus three more 0xBB,0xCC,0xDD -> next instr=0xAABBCCDD.
- Macro on, TIMEOUT_CYCLES=10: one byte, idle 10 cycles -> timeout_err pulse; next four bytes form clean word.
- reset=0 mid-word (after 3 bytes) -> all outputs 0; following four bytes produce word at addr 0.
